// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq
// Brief    : Handshaked sequential ALU; 16-cycle shift-add multiply.
// Revision : 1.0
// ============================================================================
module alu_seq #(
    parameter int W  = 32,
    parameter int MW = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [2:0]   req_op,
    input  logic [W-1:0] req_in1,
    input  logic [W-1:0] req_in2,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [W-1:0] rsp_data,
    output logic         rsp_zero
);

    localparam int CW = $clog2(MW);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_EQ  = 3'b010;
    localparam logic [2:0] OP_GT  = 3'b011;
    localparam logic [2:0] OP_MUL = 3'b100;
    localparam logic [2:0] OP_NOT = 3'b101;
    localparam logic [2:0] OP_AND = 3'b110;
    localparam logic [2:0] OP_OR  = 3'b111;

    localparam logic [CW-1:0] CNT_LAST = CW'(MW - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t          state_q;
    logic [MW-1:0]   mcand_q;
    logic [MW-1:0]   mplier_q;
    logic [W-1:0]    acc_q;
    logic [CW-1:0]   cnt_q;
    logic [W-1:0]    rsp_data_q;
    logic            rsp_zero_q;
    logic            rsp_valid_q;
    logic            req_ready_q;

    logic [W-1:0]    alu_res_d;
    logic [W-1:0]    pprod_d;
    logic [W-1:0]    acc_d;

    // Single-cycle operations, evaluated straight from the request inputs.
    always_comb begin
        alu_res_d = '0;
        case (req_op)
            OP_ADD:  alu_res_d = req_in1 + req_in2;
            OP_SUB:  alu_res_d = req_in1 - req_in2;
            OP_EQ:   alu_res_d = {{(W-1){1'b0}}, (req_in1 == req_in2)};
            OP_GT:   alu_res_d = {{(W-1){1'b0}}, ($signed(req_in1) > $signed(req_in2))};
            OP_NOT:  alu_res_d = ~req_in1;
            OP_AND:  alu_res_d = req_in1 & req_in2;
            OP_OR:   alu_res_d = req_in1 | req_in2;
            default: alu_res_d = '0;
        endcase
    end

    always_comb begin
        pprod_d = '0;
        if (mplier_q[0]) begin
            pprod_d = {{(W-MW){1'b0}}, mcand_q} << cnt_q;
        end
        acc_d = acc_q + pprod_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            rsp_data_q  <= '0;
            rsp_zero_q  <= 1'b1;
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        req_ready_q <= 1'b0;
                        if (req_op == OP_MUL) begin
                            mcand_q  <= req_in1[MW-1:0];
                            mplier_q <= req_in2[MW-1:0];
                            acc_q    <= '0;
                            cnt_q    <= '0;
                            state_q  <= S_MUL;
                        end else begin
                            rsp_data_q  <= alu_res_d;
                            rsp_zero_q  <= (alu_res_d == '0);
                            rsp_valid_q <= 1'b1;
                            state_q     <= S_RESP;
                        end
                    end
                end
                S_MUL: begin
                    acc_q    <= acc_d;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + 1'b1;
                    // The last iteration's sum goes straight to the response.
                    if (cnt_q == CNT_LAST) begin
                        rsp_data_q  <= acc_d;
                        rsp_zero_q  <= (acc_d == '0);
                        rsp_valid_q <= 1'b1;
                        state_q     <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    rsp_valid_q <= 1'b0;
                    req_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_zero  = rsp_zero_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_seq
// Brief    : Directed, table-driven self-checking bench for alu_seq.
// Revision : 1.0
// ============================================================================
module tb_alu_seq;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_in1;
    logic [31:0] req_in2;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_zero;

    int n_tests;
    int n_fail;

    alu_seq #(.W(32), .MW(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_in1   (req_in1),
        .req_in2   (req_in2),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_zero  (rsp_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[16];

    logic watch_rv;
    logic rv_rose;
    always @(posedge rsp_valid) if (watch_rv) rv_rose = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Issues one request, waits for the response, then completes the handshake.
    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] d, output logic z, output int lat,
                         output logic rdy_low, output logic tmo);
        int guard;
        @(negedge clk);
        req_op = op; req_in1 = a; req_in2 = b; req_valid = 1'b1;
        guard = 0;
        while (!req_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        lat = 1;
        rdy_low = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        req_in1 = 32'hDEAD_BEEF; req_in2 = 32'hDEAD_BEEF;
        while (!rsp_valid && lat < 40) begin
            if (req_ready) rdy_low = 1'b0;
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        tmo = !rsp_valid;
        d = rsp_data;
        z = rsp_zero;
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] d;
        logic        z;
        int          lat;
        logic        rl;
        logic        tmo;

        n_tests = 0;
        n_fail  = 0;
        watch_rv = 1'b0;
        rv_rose  = 1'b0;

        vecs[0]  = '{"ADD 5,8",        3'b000, 32'd5,          32'd8,          32'd13,         1};
        vecs[1]  = '{"ADD ovf",        3'b000, 32'h7FFF_FFFF,  32'd1,          32'h8000_0000,  1};
        vecs[2]  = '{"SUB 10,3",       3'b001, 32'd10,         32'd3,          32'd7,          1};
        vecs[3]  = '{"SUB 3,3",        3'b001, 32'd3,          32'd3,          32'd0,          1};
        vecs[4]  = '{"EQ 15,15",       3'b010, 32'd15,         32'd15,         32'd1,          1};
        vecs[5]  = '{"EQ 15,16",       3'b010, 32'd15,         32'd16,         32'd0,          1};
        vecs[6]  = '{"GT 20,10",       3'b011, 32'd20,         32'd10,         32'd1,          1};
        vecs[7]  = '{"GT -5,3",        3'b011, 32'hFFFF_FFFB,  32'd3,          32'd0,          1};
        vecs[8]  = '{"GT 3,-5",        3'b011, 32'd3,          32'hFFFF_FFFB,  32'd1,          1};
        vecs[9]  = '{"MUL 4,8",        3'b100, 32'd4,          32'd8,          32'd32,         17};
        vecs[10] = '{"MUL hi a",       3'b100, 32'h0001_0004,  32'd8,          32'd32,         17};
        vecs[11] = '{"MUL FFFF^2",     3'b100, 32'h0000_FFFF,  32'h0000_FFFF,  32'hFFFE_0001,  17};
        vecs[12] = '{"MUL hi b",       3'b100, 32'd3,          32'hABCD_0005,  32'd15,         17};
        vecs[13] = '{"NOT",            3'b101, 32'h0000_FFFF,  32'h1234_5678,  32'hFFFF_0000,  1};
        vecs[14] = '{"AND",            3'b110, 32'h0000_F0F0,  32'h0000_FF00,  32'h0000_F000,  1};
        vecs[15] = '{"OR",             3'b111, 32'h0000_F0F0,  32'h0000_0F0F,  32'h0000_FFFF,  1};

        rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
        req_op = 3'b000; req_in1 = '0; req_in2 = '0;
        repeat (3) @(negedge clk);
        chk("reset req_ready", {31'd0, req_ready}, 32'd1);
        chk("reset rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("reset rsp_data",  rsp_data,           32'd0);
        chk("reset rsp_zero",  {31'd0, rsp_zero},  32'd1);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 16; i++) begin
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, d, z, lat, rl, tmo);
            chk({vecs[i].name, " timeout"}, {31'd0, tmo}, 32'd0);
            chk({vecs[i].name, " data"}, d, vecs[i].exp);
            chk({vecs[i].name, " zero"}, {31'd0, z}, {31'd0, (vecs[i].exp == 32'd0)});
            chk({vecs[i].name, " latency"}, 32'(lat), 32'(vecs[i].lat));
            if (vecs[i].lat > 1)
                chk({vecs[i].name, " req_ready low"}, {31'd0, rl}, 32'd1);
            chk({vecs[i].name, " ready after hs"}, {31'd0, req_ready}, 32'd1);
        end

        // Backpressure: response held, a stray request in the window is refused.
        @(negedge clk);
        req_op = 3'b000; req_in1 = 32'd2; req_in2 = 32'd3; req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            if (c == 2) begin
                req_op = 3'b000; req_in1 = 32'd100; req_in2 = 32'd100; req_valid = 1'b1;
            end else begin
                req_valid = 1'b0;
            end
            chk("bp rsp_valid", {31'd0, rsp_valid}, 32'd1);
            chk("bp rsp_data",  rsp_data, 32'd5);
            chk("bp req_ready", {31'd0, req_ready}, 32'd0);
            @(posedge clk);
            @(negedge clk);
        end
        req_valid = 1'b0;
        chk("bp data held", rsp_data, 32'd5);
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("bp after hs rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("bp after hs req_ready", {31'd0, req_ready}, 32'd1);
        do_op(3'b000, 32'd1, 32'd2, d, z, lat, rl, tmo);
        chk("bp next data", d, 32'd3);
        chk("bp next latency", 32'(lat), 32'd1);

        // Reset in the middle of a multiply.
        @(negedge clk);
        req_op = 3'b100; req_in1 = 32'h0000_FFFF; req_in2 = 32'h0000_FFFF; req_valid = 1'b1;
        @(posedge clk);
        watch_rv = 1'b1;
        rv_rose  = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (8) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("mid-mul rst req_ready", {31'd0, req_ready}, 32'd1);
        chk("mid-mul rst rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("mid-mul rst rsp_data",  rsp_data, 32'd0);
        chk("mid-mul rst rsp_zero",  {31'd0, rsp_zero}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        chk("mid-mul no rsp_valid", {31'd0, rv_rose}, 32'd0);
        watch_rv = 1'b0;
        do_op(3'b000, 32'd1, 32'd1, d, z, lat, rl, tmo);
        chk("post-rst ADD data", d, 32'd2);
        chk("post-rst ADD zero", {31'd0, z}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
